// File: rtl/scpad_pkg.sv
// scpad_pkg: shared command type, FSM state encoding and default widths for the
// scratchpad backend scheduling path.
package scpad_pkg;

  localparam int unsigned SCPAD_NUM_REQ     = 3;
  localparam int unsigned SCPAD_SPAD_ADDR_W = 20;
  localparam int unsigned SCPAD_DRAM_ADDR_W = 32;
  localparam int unsigned SCPAD_DIM_W       = 5;
  localparam int unsigned SCPAD_TAG_W       = 4;

  // One tile-transfer command as held for the backend.
  typedef struct packed {
    logic                         write;
    logic [SCPAD_SPAD_ADDR_W-1:0] spad_addr;
    logic [SCPAD_DRAM_ADDR_W-1:0] dram_addr;
    logic [SCPAD_DIM_W-1:0]       num_rows;
    logic [SCPAD_DIM_W-1:0]       num_cols;
    logic [SCPAD_TAG_W-1:0]       tag;
  } sched_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // Next round-robin index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick; the search starts at ptr
// and wraps, returning a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               grant_valid_c
);

  int unsigned      idx;
  logic [IDX_W-1:0] sel;

  // First asserted request at or after ptr wins.
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    idx           = '0;
    sel           = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = IDX_W'(idx);
      if (!grant_valid_c && req[sel]) begin
        grant_valid_c = 1'b1;
        grant_c[sel]  = 1'b1;
        grant_idx_c   = sel;
      end
    end
  end

endmodule

// File: rtl/scpad_sched_arbiter.sv
// scpad_sched_arbiter: shares one scratchpad backend slot among NUM_REQ
// requesters. Accepts one command at a time, holds it on sched_* until the
// backend completes, returns a tagged done pulse and inserts one drain cycle.
// Optional build macro SCHED_TIMEOUT_EN adds a WAIT timeout (TIMEOUT_CYC),
// done_error and the sticky spurious_seen flag.
module scpad_sched_arbiter
  import scpad_pkg::*;
#(
  parameter int unsigned NUM_REQ     = SCPAD_NUM_REQ,
  parameter int unsigned SPAD_ADDR_W = SCPAD_SPAD_ADDR_W,
  parameter int unsigned DRAM_ADDR_W = SCPAD_DRAM_ADDR_W,
  parameter int unsigned DIM_W       = SCPAD_DIM_W,
  parameter int unsigned TAG_W       = SCPAD_TAG_W
`ifdef SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*SPAD_ADDR_W-1:0] req_spad_addr,
  input  logic [NUM_REQ*DRAM_ADDR_W-1:0] req_dram_addr,
  input  logic [NUM_REQ*DIM_W-1:0]      req_num_rows,
  input  logic [NUM_REQ*DIM_W-1:0]      req_num_cols,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  output logic                          sched_valid,
  output logic                          sched_write,
  output logic [SPAD_ADDR_W-1:0]        sched_spad_addr,
  output logic [DRAM_ADDR_W-1:0]        sched_dram_addr,
  output logic [DIM_W-1:0]              sched_num_rows,
  output logic [DIM_W-1:0]              sched_num_cols,
  input  logic                          sched_res_valid,
  output logic [NUM_REQ-1:0]            done_valid,
  output logic [TAG_W-1:0]              done_tag,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef SCHED_TIMEOUT_EN
  , output logic                        done_error
  , output logic                        spurious_seen
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sched_state_e       state_q, state_d;
  sched_cmd_t         cmd_q, cmd_d;
  sched_cmd_t         req_cmd [NUM_REQ];
  logic               sched_valid_q, sched_valid_d;
  logic [NUM_REQ-1:0] done_valid_q, done_valid_d;
  logic [TAG_W-1:0]   done_tag_q, done_tag_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] arb_grant_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_valid_c;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_error_q, done_error_d;
  logic             spurious_q, spurious_d;
`endif

  // Slice the packed per-requester buses into command records.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_cmd[g] = '{
      write:     req_write[g],
      spad_addr: SCPAD_SPAD_ADDR_W'(req_spad_addr[g*SPAD_ADDR_W +: SPAD_ADDR_W]),
      dram_addr: SCPAD_DRAM_ADDR_W'(req_dram_addr[g*DRAM_ADDR_W +: DRAM_ADDR_W]),
      num_rows:  SCPAD_DIM_W'(req_num_rows[g*DIM_W +: DIM_W]),
      num_cols:  SCPAD_DIM_W'(req_num_cols[g*DIM_W +: DIM_W]),
      tag:       SCPAD_TAG_W'(req_tag[g*TAG_W +: TAG_W])
    };
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req           (req_valid),
    .ptr           (rr_ptr_q),
    .grant_c       (arb_grant_c),
    .grant_idx_c   (arb_idx_c),
    .grant_valid_c (arb_valid_c)
  );

  // Only IDLE may accept; the arbiter grant is already one-hot.
  assign req_ready = (state_q == ST_IDLE) ? arb_grant_c : '0;

  // Next-state and next registered-output values.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    sched_valid_d = sched_valid_q;
    done_valid_d  = '0;
    done_tag_d    = done_tag_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_d         = cnt_q;
    done_error_d  = 1'b0;
    spurious_d    = spurious_q | (sched_res_valid && (state_q != ST_WAIT));
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          state_d       = ST_ISSUE;
          sched_valid_d = 1'b1;
          cmd_d         = req_cmd[arb_idx_c];
          grant_id_d    = arb_idx_c;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (sched_res_valid) begin
          state_d                  = ST_DRAIN;
          sched_valid_d            = 1'b0;
          done_valid_d[grant_id_q] = 1'b1;
          done_tag_d               = TAG_W'(cmd_q.tag);
          rr_ptr_d                 = IDX_W'(rr_next(32'(grant_id_q), NUM_REQ));
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d                  = ST_DRAIN;
          sched_valid_d            = 1'b0;
          done_valid_d[grant_id_q] = 1'b1;
          done_error_d             = 1'b1;
          done_tag_d               = TAG_W'(cmd_q.tag);
          rr_ptr_d                 = IDX_W'(rr_next(32'(grant_id_q), NUM_REQ));
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      sched_valid_q <= 1'b0;
      done_valid_q  <= '0;
      done_tag_q    <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      busy_q        <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      done_error_q  <= 1'b0;
      spurious_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      sched_valid_q <= sched_valid_d;
      done_valid_q  <= done_valid_d;
      done_tag_q    <= done_tag_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= (state_d != ST_IDLE);
`ifdef SCHED_TIMEOUT_EN
      cnt_q         <= cnt_d;
      done_error_q  <= done_error_d;
      spurious_q    <= spurious_d;
`endif
    end
  end

  assign sched_valid     = sched_valid_q;
  assign sched_write     = cmd_q.write;
  assign sched_spad_addr = SPAD_ADDR_W'(cmd_q.spad_addr);
  assign sched_dram_addr = DRAM_ADDR_W'(cmd_q.dram_addr);
  assign sched_num_rows  = DIM_W'(cmd_q.num_rows);
  assign sched_num_cols  = DIM_W'(cmd_q.num_cols);
  assign done_valid      = done_valid_q;
  assign done_tag        = done_tag_q;
  assign busy            = busy_q;
  assign grant_id        = grant_id_q;
`ifdef SCHED_TIMEOUT_EN
  assign done_error      = done_error_q;
  assign spurious_seen   = spurious_q;
`endif

endmodule

// File: tb/tb_scpad_sched_arbiter.sv
// tb_scpad_sched_arbiter: directed checks of the scratchpad scheduler arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_scpad_sched_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned SW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 5;
  localparam int unsigned TW = 4;
  localparam int unsigned IW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req_valid;
  logic [NR-1:0]       req_ready;
  logic [NR-1:0]       req_write;
  logic [NR*SW-1:0]    req_spad_addr;
  logic [NR*DW-1:0]    req_dram_addr;
  logic [NR*MW-1:0]    req_num_rows;
  logic [NR*MW-1:0]    req_num_cols;
  logic [NR*TW-1:0]    req_tag;
  logic                sched_valid;
  logic                sched_write;
  logic [SW-1:0]       sched_spad_addr;
  logic [DW-1:0]       sched_dram_addr;
  logic [MW-1:0]       sched_num_rows;
  logic [MW-1:0]       sched_num_cols;
  logic                sched_res_valid;
  logic [NR-1:0]       done_valid;
  logic [TW-1:0]       done_tag;
  logic                busy;
  logic [IW-1:0]       grant_id;
`ifdef SCHED_TIMEOUT_EN
  logic                done_error;
  logic                spurious_seen;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scpad_sched_arbiter #(
    .NUM_REQ     (NR),
    .SPAD_ADDR_W (SW),
    .DRAM_ADDR_W (DW),
    .DIM_W       (MW),
    .TAG_W       (TW)
`ifdef SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_spad_addr   (req_spad_addr),
    .req_dram_addr   (req_dram_addr),
    .req_num_rows    (req_num_rows),
    .req_num_cols    (req_num_cols),
    .req_tag         (req_tag),
    .sched_valid     (sched_valid),
    .sched_write     (sched_write),
    .sched_spad_addr (sched_spad_addr),
    .sched_dram_addr (sched_dram_addr),
    .sched_num_rows  (sched_num_rows),
    .sched_num_cols  (sched_num_cols),
    .sched_res_valid (sched_res_valid),
    .done_valid      (done_valid),
    .done_tag        (done_tag),
    .busy            (busy),
    .grant_id        (grant_id)
`ifdef SCHED_TIMEOUT_EN
    , .done_error    (done_error)
    , .spurious_seen (spurious_seen)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic wr, input logic [SW-1:0] sp,
                         input logic [DW-1:0] dr, input logic [MW-1:0] nr,
                         input logic [MW-1:0] nc, input logic [TW-1:0] tg);
    req_write[r]              = wr;
    req_spad_addr[r*SW +: SW] = sp;
    req_dram_addr[r*DW +: DW] = dr;
    req_num_rows[r*MW +: MW]  = nr;
    req_num_cols[r*MW +: MW]  = nc;
    req_tag[r*TW +: TW]       = tg;
  endtask

  // Raise only requester r, wait (bounded) for its accept, leave the bench
  // at the start of the first WAIT cycle.
  task automatic xfer_start(input int r);
    int n;
    n = 0;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    smp();
    while (req_ready == '0 && n < 16) begin
      step();
      smp();
      n++;
    end
    check_eq("xs_ready", 64'(req_ready), 64'(1 << r));
    step();
    req_valid = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last;
    rst             = 1'b1;
    req_valid       = '0;
    req_write       = '0;
    req_spad_addr   = '0;
    req_dram_addr   = '0;
    req_num_rows    = '0;
    req_num_cols    = '0;
    req_tag         = '0;
    sched_res_valid = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    smp();
    check_eq("rst_sched_valid", 64'(sched_valid), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done_valid", 64'(done_valid), 0);
    check_eq("rst_req_ready", 64'(req_ready), 0);
    check_eq("rst_grant_id", 64'(grant_id), 0);
    check_eq("rst_done_tag", 64'(done_tag), 0);
    check_eq("rst_spad", 64'(sched_spad_addr), 0);
    check_eq("rst_dram", 64'(sched_dram_addr), 0);

    // Single request: accept in cycle 0, issue in cycle 1, complete at 10
    step();
    set_req(0, 1'b0, 20'h00100, 32'h8000_0000, 5'd3, 5'd31, 4'd5);
    req_valid = 3'b001;
    smp();
    check_eq("t1_ready_c0", 64'(req_ready), 3'b001);
    step();
    req_valid = '0;
    smp();
    check_eq("t1_sched_valid_c1", 64'(sched_valid), 1);
    check_eq("t1_write", 64'(sched_write), 0);
    check_eq("t1_spad", 64'(sched_spad_addr), 20'h00100);
    check_eq("t1_dram", 64'(sched_dram_addr), 32'h8000_0000);
    check_eq("t1_rows", 64'(sched_num_rows), 3);
    check_eq("t1_cols", 64'(sched_num_cols), 31);
    check_eq("t1_busy", 64'(busy), 1);
    check_eq("t1_grant_id", 64'(grant_id), 0);
    check_eq("t1_ready_issue", 64'(req_ready), 0);
    for (int c = 2; c <= 9; c++) begin
      step();
      set_req(0, 1'b1, SW'($urandom), $urandom, MW'($urandom), MW'($urandom), TW'($urandom));
      smp();
      check_eq("hold_valid", 64'(sched_valid), 1);
      check_eq("hold_write", 64'(sched_write), 0);
      check_eq("hold_spad", 64'(sched_spad_addr), 20'h00100);
      check_eq("hold_dram", 64'(sched_dram_addr), 32'h8000_0000);
      check_eq("hold_rows", 64'(sched_num_rows), 3);
      check_eq("hold_cols", 64'(sched_num_cols), 31);
      check_eq("hold_done", 64'(done_valid), 0);
    end
    step();
    sched_res_valid = 1'b1;
    smp();
    check_eq("t1_done_c10", 64'(done_valid), 0);
    check_eq("t1_valid_c10", 64'(sched_valid), 1);
    step();
    sched_res_valid = 1'b0;
    smp();
    check_eq("t1_done_c11", 64'(done_valid), 3'b001);
    check_eq("t1_tag_c11", 64'(done_tag), 5);
    check_eq("t1_valid_c11", 64'(sched_valid), 0);
    check_eq("t1_busy_drain", 64'(busy), 1);
    check_eq("t1_ready_drain", 64'(req_ready), 0);
    step();
    smp();
    check_eq("t1_done_c12", 64'(done_valid), 0);
    check_eq("t1_busy_c12", 64'(busy), 0);

    // Round robin with all requesters continuously valid: 0,1,2,0
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_req(r, (r == 2), SW'(32'h1000 * (r + 1)), 32'hA000_0000 + r, MW'(r), MW'(r + 1), TW'(8 + r));
    end
    req_valid = 3'b111;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      int exp_r;
      int n;
      exp_r = k % 3;
      n = 0;
      smp();
      while (req_ready == '0 && n < 16) begin
        step();
        smp();
        n++;
      end
      check_eq("rr_ready", 64'(req_ready), 64'(1 << exp_r));
      if (k > 0) check_eq("rr_spacing", 64'(cyc - last), 4);
      last = cyc;
      step();
      smp();
      check_eq("rr_grant_id", 64'(grant_id), 64'(exp_r));
      check_eq("rr_sched_valid", 64'(sched_valid), 1);
      check_eq("rr_spad", 64'(sched_spad_addr), 64'(32'h1000 * (exp_r + 1)));
      check_eq("rr_write", 64'(sched_write), 64'(exp_r == 2));
      step();
      sched_res_valid = 1'b1;
      step();
      sched_res_valid = 1'b0;
      smp();
      check_eq("rr_done", 64'(done_valid), 64'(1 << exp_r));
      check_eq("rr_tag", 64'(done_tag), 64'(8 + exp_r));
      check_eq("rr_ready_drain", 64'(req_ready), 0);
      step();
    end

    // Spurious completion in IDLE, then a request withdrawn before accept
    req_valid = '0;
    sched_res_valid = 1'b1;
    step();
    sched_res_valid = 1'b0;
    smp();
    check_eq("sp_done", 64'(done_valid), 0);
    check_eq("sp_busy", 64'(busy), 0);
    check_eq("sp_sched_valid", 64'(sched_valid), 0);
`ifdef SCHED_TIMEOUT_EN
    check_eq("sp_seen", 64'(spurious_seen), 1);
`endif
    req_valid = 3'b100;
    #1;
    check_eq("sp_ready_idle", 64'(req_ready), 3'b100);
    req_valid = '0;
    step();
    smp();
    check_eq("drop_busy", 64'(busy), 0);

    // Reset during WAIT clears the round-robin pointer
    step();
    xfer_start(1);
    sched_res_valid = 1'b1;
    step();
    sched_res_valid = 1'b0;
    step();
    xfer_start(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp();
    check_eq("wr_sched_valid", 64'(sched_valid), 0);
    check_eq("wr_busy", 64'(busy), 0);
    check_eq("wr_done", 64'(done_valid), 0);
    check_eq("wr_grant_id", 64'(grant_id), 0);
    req_valid = 3'b110;
    #1;
    check_eq("wr_rr_ptr_zero", 64'(req_ready), 3'b010);
    req_valid = '0;
    step();
    smp();
    check_eq("wr_done_after", 64'(done_valid), 0);

`ifdef SCHED_TIMEOUT_EN
    // Timeout with no backend response: done 16 cycles after entering WAIT
    step();
    xfer_start(0);
    for (int c = 2; c <= 17; c++) begin
      smp();
      if (c == 17) begin
        check_eq("to_done_early", 64'(done_valid), 0);
        check_eq("to_valid_c17", 64'(sched_valid), 1);
      end
      step();
    end
    smp();
    check_eq("to_done", 64'(done_valid), 3'b001);
    check_eq("to_error", 64'(done_error), 1);
    check_eq("to_sched_valid", 64'(sched_valid), 0);
    check_eq("to_busy_drain", 64'(busy), 1);
    step();
    smp();
    check_eq("to_busy_idle", 64'(busy), 0);
    check_eq("to_error_clr", 64'(done_error), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
